// File: rtl/hoaaned_sub_monitor.sv
// Two-stage approximate subtractor (near-normal-error lower part) with an exact
// reference path and saturating error statistics on the output handshake.
module hoaaned_sub_monitor #(
  parameter int N     = 16,
  parameter int P     = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     X,
  input  logic [N-1:0]     Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     DIFF,
  output logic             BORROW,
  output logic [N:0]       ERR,
  input  logic             clr_stats,
  output logic [ACC_W-1:0] err_sum,
  output logic [N:0]       err_max,
  output logic [CNT_W-1:0] n_samples
);

  // Sum is evaluated one bit wider than both the accumulator and ERR so the
  // saturation compare sees every overflow.
  localparam int SW = ((ACC_W > N + 1) ? ACC_W : N + 1) + 1;

  logic [N-1:0]     w_b;
  logic             w_c;
  logic [P-1:0]     w_alo;
  logic [N-P:0]     w_ahi;
  logic [N:0]       w_a;
  logic [N:0]       w_e;
  logic [N:0]       w_err;
  logic             w_stall;
  logic             w_hs;
  logic [SW-1:0]    w_sum_full;

  logic [2:1]       r_vld_pipe;
  logic [N:0]       r_a;
  logic [N:0]       r_e;
  logic [N-1:0]     r_diff;
  logic             r_borrow;
  logic [N:0]       r_err;
  logic [ACC_W-1:0] r_sum;
  logic [N:0]       r_max;
  logic [CNT_W-1:0] r_cnt;

  assign w_b = ~Y;
  assign w_c = X[P-1] & w_b[P-1];

  always_comb begin
    w_alo       = '1;
    w_alo[P-2]  = X[P-2] | w_b[P-2];
    w_alo[P-1]  = (w_c ? 1'b0 : (X[P-1] | w_b[P-1])) | (X[P-2] & w_b[P-2]);
  end

  assign w_ahi = {1'b0, X[N-1:P]} + {1'b0, w_b[N-1:P]} + {{(N-P){1'b0}}, w_c};
  assign w_a   = {w_ahi, w_alo};
  assign w_e   = {1'b0, X} + {1'b0, w_b} + {{N{1'b0}}, 1'b1};

  assign w_stall  = r_vld_pipe[2] & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_hs     = r_vld_pipe[2] & out_ready;

  // Stage 1: approximate and exact sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_a        <= '0;
      r_e        <= '0;
    end else if (!w_stall) begin
      r_vld_pipe <= {r_vld_pipe[1], in_valid};
      if (in_valid) begin
        r_a <= w_a;
        r_e <= w_e;
      end
    end
  end

  assign w_err = (r_e >= r_a) ? (r_e - r_a) : (r_a - r_e);

  // Stage 2: results; only real data overwrites so outputs stay put across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_err    <= '0;
    end else if (!w_stall && r_vld_pipe[1]) begin
      r_diff   <= r_a[N-1:0];
      r_borrow <= ~r_a[N];
      r_err    <= w_err;
    end
  end

  assign w_sum_full = SW'(r_sum) + SW'(r_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else if (clr_stats) begin
      r_sum <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else if (w_hs) begin
      r_sum <= (w_sum_full > SW'({ACC_W{1'b1}})) ? '1 : w_sum_full[ACC_W-1:0];
      if (r_err > r_max) r_max <= r_err;
      if (r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid = r_vld_pipe[2];
  assign DIFF      = r_diff;
  assign BORROW    = r_borrow;
  assign ERR       = r_err;
  assign err_sum   = r_sum;
  assign err_max   = r_max;
  assign n_samples = r_cnt;

endmodule

// File: tb/tb_hoaaned_sub_monitor.sv
// Directed bench: scoreboard of expected results, compared at the output
// handshake; a second narrow-counter instance exercises saturation.
module tb_hoaaned_sub_monitor;

  localparam int N = 16;
  localparam int P = 8;

  typedef struct packed {
    logic [N-1:0] diff;
    logic         borrow;
    logic [N:0]   err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          in_valid, in_ready, out_valid, out_ready, clr_stats;
  logic [N-1:0]  X, Y, DIFF;
  logic          BORROW;
  logic [N:0]    ERR, err_max;
  logic [31:0]   err_sum;
  logic [23:0]   n_samples;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_clr;
  logic [N-1:0]  s_X, s_Y, s_DIFF;
  logic          s_BORROW;
  logic [N:0]    s_ERR, s_max;
  logic [3:0]    s_sum;
  logic [3:0]    s_n;

  logic bp_en = 1'b0;
  logic or_lvl = 1'b1;
  int   bp_cnt = 0;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Backpressure pattern 1,0,0,1,0,0...
  always @(posedge clk) bp_cnt <= (bp_cnt == 2) ? 0 : bp_cnt + 1;
  assign out_ready = bp_en ? (bp_cnt == 0) : or_lvl;

  hoaaned_sub_monitor #(.N(N), .P(P), .ACC_W(32), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
    .DIFF(DIFF), .BORROW(BORROW), .ERR(ERR), .clr_stats(clr_stats),
    .err_sum(err_sum), .err_max(err_max), .n_samples(n_samples)
  );

  hoaaned_sub_monitor #(.N(N), .P(P), .ACC_W(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .X(s_X), .Y(s_Y), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .DIFF(s_DIFF), .BORROW(s_BORROW), .ERR(s_ERR), .clr_stats(s_clr),
    .err_sum(s_sum), .err_max(s_max), .n_samples(s_n)
  );

  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] b;
    logic [N:0]   a, e;
    logic         c;
    exp_t         r;
    b        = ~y;
    a        = '1;
    a[P-2]   = x[P-2] | b[P-2];
    c        = x[P-1] & b[P-1];
    a[P-1]   = (c ? 1'b0 : (x[P-1] | b[P-1])) | (x[P-2] & b[P-2]);
    a[N:P]   = {1'b0, x[N-1:P]} + {1'b0, b[N-1:P]} + {{(N-P){1'b0}}, c};
    e        = {1'b0, x} + {1'b0, b} + {{N{1'b0}}, 1'b1};
    r.diff   = a[N-1:0];
    r.borrow = ~a[N];
    r.err    = (e > a) ? (e - a) : (a - e);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input exp_t e);
    bit done;
    done     = 0;
    X        = x;
    Y        = y;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1 within 40 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_left", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Output side: head of the scoreboard must be on the bus whenever out_valid,
  // which also proves stability while stalled; pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_out: observed DIFF=%0h expected no output", DIFF);
      end else begin
        chk("diff",   64'(DIFF),   64'(sb[0].diff));
        chk("borrow", 64'(BORROW), 64'(sb[0].borrow));
        chk("err",    64'(ERR),    64'(sb[0].err));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [N-1:0] rx, ry;
    exp_t         re;
    logic [31:0]  esum;
    in_valid = 1'b0; X = '0; Y = '0; clr_stats = 1'b0;
    s_in_valid = 1'b0; s_X = 16'h1234; s_Y = 16'h0034; s_out_ready = 1'b1; s_clr = 1'b0;

    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_diff",      64'(DIFF),      64'(0));
    chk("rst_err",       64'(ERR),       64'(0));
    chk("rst_sum",       64'(err_sum),   64'(0));
    chk("rst_max",       64'(err_max),   64'(0));
    chk("rst_n",         64'(n_samples), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Latency from an empty pipe
    send(16'h1234, 16'h0034, '{diff: 16'h11FF, borrow: 1'b0, err: 17'd1});
    chk("lat_stage1", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_stage2", 64'(out_valid), 64'(1));
    drain();

    clr_stats = 1'b1; @(posedge clk); #1 clr_stats = 1'b0;
    send(16'h0080, 16'h0000, '{diff: 16'h007F, borrow: 1'b0, err: 17'd1});
    send(16'h1234, 16'h0034, '{diff: 16'h11FF, borrow: 1'b0, err: 17'd1});
    send(16'h0000, 16'h0001, '{diff: 16'hFFFF, borrow: 1'b1, err: 17'd0});
    send(16'h00FF, 16'h00FF, '{diff: 16'hFFFF, borrow: 1'b1, err: 17'd1});
    drain();
    chk("stats_n",   64'(n_samples), 64'(4));
    chk("stats_sum", 64'(err_sum),   64'(3));
    chk("stats_max", 64'(err_max),   64'(1));

    // Backpressure with random operands
    clr_stats = 1'b1; @(posedge clk); #1 clr_stats = 1'b0;
    bp_en = 1'b1;
    esum  = '0;
    for (int k = 0; k < 5; k++) begin
      rx = N'($urandom);
      ry = N'($urandom);
      re = model(rx, ry);
      esum += 32'(re.err);
      send(rx, ry, re);
    end
    drain();
    bp_en = 1'b0;
    chk("bp_n",   64'(n_samples), 64'(5));
    chk("bp_sum", 64'(err_sum),   64'(esum));

    // clr_stats coincident with a handshake wins
    send(16'h1234, 16'h0034, '{diff: 16'h11FF, borrow: 1'b0, err: 17'd1});
    @(posedge clk); #1;
    chk("clr_hs_valid", 64'(out_valid), 64'(1));
    clr_stats = 1'b1;
    @(posedge clk); #1 clr_stats = 1'b0;
    chk("clr_hs_n",   64'(n_samples), 64'(0));
    chk("clr_hs_sum", 64'(err_sum),   64'(0));
    chk("clr_hs_max", 64'(err_max),   64'(0));
    drain();

    // Reset with both stages full and the sink stalled
    send(16'h0080, 16'h0000, '{diff: 16'h007F, borrow: 1'b0, err: 17'd1});
    drain();
    or_lvl = 1'b0;
    send(16'h1234, 16'h0034, '{diff: 16'h11FF, borrow: 1'b0, err: 17'd1});
    send(16'h0000, 16'h0001, '{diff: 16'hFFFF, borrow: 1'b1, err: 17'd0});
    chk("full_out_valid", 64'(out_valid), 64'(1));
    chk("full_in_ready",  64'(in_ready),  64'(0));
    #3 rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready",  64'(in_ready),  64'(1));
    chk("mid_rst_n",         64'(n_samples), 64'(0));
    chk("mid_rst_sum",       64'(err_sum),   64'(0));
    chk("mid_rst_diff",      64'(DIFF),      64'(0));
    @(posedge clk); #1 rst = 1'b0;
    or_lvl = 1'b1;
    send(16'h00FF, 16'h00FF, '{diff: 16'hFFFF, borrow: 1'b1, err: 17'd1});
    chk("post_rst_lat1", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("post_rst_lat2", 64'(out_valid), 64'(1));
    drain();
    chk("post_rst_n", 64'(n_samples), 64'(1));

    // Saturation: 17 results of ERR=1 into 4-bit sum and count
    s_in_valid = 1'b1;
    repeat (17) @(posedge clk);
    #1 s_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_sum",   64'(s_sum),       64'(15));
    chk("sat_n",     64'(s_n),         64'(15));
    chk("sat_max",   64'(s_max),       64'(1));
    chk("sat_res",   64'({s_DIFF, s_BORROW, s_ERR}), 64'({16'h11FF, 1'b0, 17'd1}));
    chk("sat_valid", 64'(s_out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
